// File: rtl/insn_sram_arbiter_if.sv
// rtl/insn_sram_arbiter_if.sv - requester port bundle for the instruction SRAM arbiter
//
// Purpose: one requester's view of the shared instruction SRAM.
// Signals:
//   valid/write/addr/wen/wdata  request, held stable by the master until ready
//   ready                       grant; request accepted when valid & ready
//   rvalid/rdata                one-cycle read return, rdata is 0 when rvalid is low
// Modports: master = requester side, slave = arbiter side.
interface insn_sram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic                  write;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   wen;
    logic [DATA_W-1:0]     wdata;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output valid, write, addr, wen, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, write, addr, wen, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/insn_sram_arbiter.sv
// rtl/insn_sram_arbiter.sv - two-port arbiter for the single-port instruction SRAM
//
// Purpose: shares the 256K x 32 instruction SRAM between the CPU fetch path
// (port 0) and the boot-image preload engine (port 1). At most one access is
// granted per cycle; read data returns one cycle later to the issuing port.
// Arbitration: fixed priority (port 0 high) with a starvation guard for port 1,
// or round-robin, chosen by i_arb_mode.
// Ports:
//   hclk, n_hreset     clock, asynchronous active-low reset
//   i_arb_mode         0 = fixed priority + starvation guard, 1 = round-robin
//   req0, req1         requester bundles (slave side)
//   o_sram_cen         active-low chip enable
//   o_sram_wen         active-low byte write enables, all ones on reads/idle
//   o_sram_addr        SRAM word address
//   o_sram_din         SRAM write data
//   i_sram_dout        SRAM read data, valid the cycle after a read access
//   o_starve_cnt       consecutive cycles port 1 has been denied (debug)
module insn_sram_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  hclk,
    input  logic                  n_hreset,
    input  logic                  i_arb_mode,
    insn_sram_arbiter_if.slave    req0,
    insn_sram_arbiter_if.slave    req1,
    output logic                  o_sram_cen,
    output logic [DATA_W/8-1:0]   o_sram_wen,
    output logic [ADDR_W-1:0]     o_sram_addr,
    output logic [DATA_W-1:0]     o_sram_din,
    input  logic [DATA_W-1:0]     i_sram_dout,
    output logic [3:0]            o_starve_cnt
);
    localparam int         BE_W       = DATA_W / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       r_last_gnt;     // port id of the most recent grant
    logic [3:0] r_starve_cnt;
    logic       r_rd_vld;       // read issued last cycle, data on i_sram_dout now
    logic       r_rd_port;

    logic w_gnt0;
    logic w_gnt1;
    logic w_any_gnt;
    logic w_rd_gnt;

    // Grant decision. Gated by n_hreset so no port is accepted while reset
    // is held, even though the registers are already at their reset values.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (n_hreset) begin
            if (req0.valid && req1.valid) begin
                if (i_arb_mode) begin
                    w_gnt1 = ~r_last_gnt;
                end else begin
                    w_gnt1 = (r_starve_cnt == STARVE_LIM);
                end
                w_gnt0 = ~w_gnt1;
            end else begin
                w_gnt0 = req0.valid;
                w_gnt1 = req1.valid;
            end
        end
    end

    assign w_any_gnt = w_gnt0 | w_gnt1;
    assign w_rd_gnt  = (w_gnt0 & ~req0.write) | (w_gnt1 & ~req1.write);

    // SRAM pin mux; idle drives everything to the quiet value.
    always_comb begin
        o_sram_cen  = ~w_any_gnt;
        o_sram_wen  = '1;
        o_sram_addr = '0;
        o_sram_din  = '0;
        if (w_gnt0) begin
            o_sram_addr = req0.addr;
            o_sram_din  = req0.wdata;
            o_sram_wen  = req0.write ? req0.wen : {BE_W{1'b1}};
        end else if (w_gnt1) begin
            o_sram_addr = req1.addr;
            o_sram_din  = req1.wdata;
            o_sram_wen  = req1.write ? req1.wen : {BE_W{1'b1}};
        end
    end

    always_ff @(posedge hclk or negedge n_hreset) begin
        if (!n_hreset) begin
            r_last_gnt   <= 1'b1;
            r_starve_cnt <= 4'd0;
            r_rd_vld     <= 1'b0;
            r_rd_port    <= 1'b0;
        end else begin
            // Counts only uninterrupted denials of a waiting port 1.
            if (i_arb_mode || !req1.valid || w_gnt1) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            if (w_any_gnt) begin
                r_last_gnt <= w_gnt1;
            end
            r_rd_vld  <= w_rd_gnt;
            r_rd_port <= w_gnt1;
        end
    end

    assign req0.ready  = w_gnt0;
    assign req1.ready  = w_gnt1;
    assign req0.rvalid = r_rd_vld & ~r_rd_port;
    assign req1.rvalid = r_rd_vld &  r_rd_port;
    assign req0.rdata  = req0.rvalid ? i_sram_dout : '0;
    assign req1.rdata  = req1.rvalid ? i_sram_dout : '0;

    assign o_starve_cnt = r_starve_cnt;
endmodule

// File: tb/tb_insn_sram_arbiter.sv
// tb/tb_insn_sram_arbiter.sv - self-checking bench for insn_sram_arbiter
module tb_insn_sram_arbiter;
    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              hclk = 1'b0;
    logic              n_hreset = 1'b0;
    logic              arb_mode = 1'b0;
    logic              sram_cen;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_din;
    logic [31:0]       sram_dout = '0;
    logic [3:0]        starve_cnt;

    insn_sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if0 ();
    insn_sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if1 ();

    insn_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .hclk         (hclk),
        .n_hreset     (n_hreset),
        .i_arb_mode   (arb_mode),
        .req0         (if0),
        .req1         (if1),
        .o_sram_cen   (sram_cen),
        .o_sram_wen   (sram_wen),
        .o_sram_addr  (sram_addr),
        .o_sram_din   (sram_din),
        .i_sram_dout  (sram_dout),
        .o_starve_cnt (starve_cnt)
    );

    always #5 hclk = ~hclk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] wen);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (!wen[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SRAM device model driven by the DUT pins
    logic [31:0] sram_mem [0:(1<<ADDR_W)-1];
    always @(posedge hclk) begin
        if (!sram_cen) begin
            sram_dout <= sram_mem[sram_addr];
            sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_din, sram_wen);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected memory contents and arbitration history
    logic [31:0] ref_mem [int];
    int          m_starve;
    int          m_last;
    bit          m_rd_vld;
    int          m_rd_port;
    logic [31:0] m_rd_data;

    int          g_w;
    logic        obs_rv0, obs_rv1;
    logic [31:0] obs_rd0, obs_rd1;
    logic [3:0]  obs_starve;
    int          starve_seq [6] = '{0, 1, 2, 3, 4, 0};

    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic model_reset();
        m_starve = 0;
        m_last   = 1;
        m_rd_vld = 0;
    endtask

    task automatic set_req(input int p, input bit v, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [3:0] e, input logic [31:0] d);
        if (p == 0) begin
            if0.valid = v; if0.write = wr; if0.addr = a; if0.wen = e; if0.wdata = d;
        end else begin
            if1.valid = v; if1.write = wr; if1.addr = a; if1.wen = e; if1.wdata = d;
        end
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        int w;
        bit wr;
        logic [ADDR_W-1:0] a;
        logic [3:0] e;
        logic [31:0] d;
        bit ev0, ev1;
        @(negedge hclk);
        if (!n_hreset) model_reset();
        w = -1;
        if (n_hreset) begin
            if (if0.valid && if1.valid) begin
                if (arb_mode) w = 1 - m_last;
                else w = (m_starve >= STARVE_MAX) ? 1 : 0;
            end else if (if0.valid) w = 0;
            else if (if1.valid) w = 1;
        end
        wr = 0; a = '0; e = 4'hF; d = '0;
        if (w == 0) begin wr = if0.write; a = if0.addr; e = if0.wen; d = if0.wdata; end
        if (w == 1) begin wr = if1.write; a = if1.addr; e = if1.wen; d = if1.wdata; end
        ev0 = m_rd_vld && (m_rd_port == 0);
        ev1 = m_rd_vld && (m_rd_port == 1);
        check("ready0",     64'(if0.ready),  64'(w == 0));
        check("ready1",     64'(if1.ready),  64'(w == 1));
        check("sram_cen",   64'(sram_cen),   64'(w < 0));
        check("sram_wen",   64'(sram_wen),   64'((w >= 0 && wr) ? e : 4'hF));
        check("sram_addr",  64'(sram_addr),  64'(a));
        check("sram_din",   64'(sram_din),   64'(d));
        check("rvalid0",    64'(if0.rvalid), 64'(ev0));
        check("rvalid1",    64'(if1.rvalid), 64'(ev1));
        check("rdata0",     64'(if0.rdata),  64'(ev0 ? m_rd_data : 32'h0));
        check("rdata1",     64'(if1.rdata),  64'(ev1 ? m_rd_data : 32'h0));
        check("starve_cnt", 64'(starve_cnt), 64'(m_starve));
        obs_rv0 = if0.rvalid; obs_rv1 = if1.rvalid;
        obs_rd0 = if0.rdata;  obs_rd1 = if1.rdata;
        obs_starve = starve_cnt;
        g_w = w;
        if (n_hreset) begin
            m_rd_vld  = (w >= 0) && !wr;
            m_rd_port = w;
            if (w >= 0 && !wr) m_rd_data = ref_rd(int'(a));
            if (w >= 0 && wr) ref_mem[int'(a)] = merge(ref_rd(int'(a)), d, e);
            if (arb_mode || !if1.valid || w == 1) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve++;
            if (w >= 0) m_last = w;
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        n_hreset = 1'b0;
        cycle();
        n_hreset = 1'b1;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(3) == 0) return 18'h3FFF0 + 18'($urandom_range(15));
        return 18'($urandom_range(15));
    endfunction

    task automatic rand_req(input int p);
        set_req(p, $urandom_range(3) != 0, 1'($urandom_range(1)), rand_addr(),
                4'($urandom_range(15)), $urandom);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] = '0;
        model_reset();
        g_w = -1;

        // Reset held with both ports requesting
        set_req(0, 1, 0, 18'h1, 4'hF, 32'h0);
        set_req(1, 1, 1, 18'h2, 4'h0, 32'h5);
        @(posedge hclk);
        #1;
        cycle();
        cycle();
        check("rst_ready0", 64'(if0.ready), 64'(0));
        check("rst_ready1", 64'(if1.ready), 64'(0));
        check("rst_cen",    64'(sram_cen),  64'(1));
        check("rst_wen",    64'(sram_wen),  64'(4'hF));

        // Port 1 single write then read
        n_hreset = 1'b1;
        set_req(0, 0, 0, 18'h0, 4'hF, 32'h0);
        set_req(1, 1, 1, 18'h10, 4'h0, 32'hDEADBEEF);
        cycle();
        check("wr1_gnt", 64'(g_w), 64'(1));
        set_req(1, 1, 0, 18'h10, 4'hF, 32'h0);
        cycle();
        check("rd1_gnt", 64'(g_w), 64'(1));
        set_req(1, 0, 0, 18'h0, 4'hF, 32'h0);
        cycle();
        check("rd1_rvalid", 64'(obs_rv1), 64'(1));
        check("rd1_rdata",  64'(obs_rd1), 64'(32'hDEADBEEF));
        check("rd1_rvalid0", 64'(obs_rv0), 64'(0));

        // Port 0 byte-masked writes at the top address
        set_req(0, 1, 1, 18'h3FFFF, 4'h0, 32'h11223344);
        cycle();
        set_req(0, 1, 1, 18'h3FFFF, 4'hF, 32'h55667788);
        cycle();
        set_req(0, 1, 1, 18'h3FFFF, 4'b1100, 32'hAABBCCDD);
        cycle();
        set_req(0, 1, 0, 18'h3FFFF, 4'hF, 32'h0);
        cycle();
        set_req(0, 0, 0, 18'h0, 4'hF, 32'h0);
        cycle();
        check("mask_rvalid", 64'(obs_rv0), 64'(1));
        check("mask_rdata",  64'(obs_rd0), 64'(32'h1122CCDD));

        // Starvation guard, mode 0
        do_reset();
        arb_mode = 1'b0;
        set_req(0, 1, 0, 18'h10, 4'hF, 32'h0);
        set_req(1, 1, 0, 18'h3FFFF, 4'hF, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            check("starve_gnt", 64'(g_w), 64'((k % 5 == 0) ? 1 : 0));
            if (k <= 6) check("starve_seq", 64'(obs_starve), 64'(starve_seq[k-1]));
        end

        // Round-robin, mode 1, from reset
        set_req(0, 0, 0, 18'h0, 4'hF, 32'h0);
        set_req(1, 0, 0, 18'h0, 4'hF, 32'h0);
        do_reset();
        arb_mode = 1'b1;
        set_req(0, 1, 0, 18'h10, 4'hF, 32'h0);
        set_req(1, 1, 0, 18'h3FFFF, 4'hF, 32'h0);
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin
                set_req(0, 0, 0, 18'h0, 4'hF, 32'h0);
                set_req(1, 0, 0, 18'h0, 4'hF, 32'h0);
            end
            cycle();
            if (k < 6) check("rr_gnt", 64'(g_w), 64'(k % 2));
            if (k >= 1) begin
                if ((k - 1) % 2 == 0) begin
                    check("rr_rv0", 64'(obs_rv0), 64'(1));
                    check("rr_rd0", 64'(obs_rd0), 64'(32'hDEADBEEF));
                end else begin
                    check("rr_rv1", 64'(obs_rv1), 64'(1));
                    check("rr_rd1", 64'(obs_rd1), 64'(32'h1122CCDD));
                end
            end
        end

        // Reset in the cycle after a port 0 read grant
        set_req(0, 1, 0, 18'h10, 4'hF, 32'h0);
        cycle();
        check("midrst_gnt", 64'(g_w), 64'(0));
        set_req(0, 0, 0, 18'h0, 4'hF, 32'h0);
        n_hreset = 1'b0;
        cycle();
        check("midrst_rv0", 64'(obs_rv0), 64'(0));
        n_hreset = 1'b1;
        set_req(0, 1, 0, 18'h10, 4'hF, 32'h0);
        set_req(1, 1, 0, 18'h10, 4'hF, 32'h0);
        cycle();
        check("midrst_rv0_after", 64'(obs_rv0), 64'(0));
        check("midrst_tie", 64'(g_w), 64'(0));

        // Randomized traffic with mode switches and occasional resets
        for (int n = 0; n < 3000; n++) begin
            if (!if0.valid || g_w == 0) rand_req(0);
            if (!if1.valid || g_w == 1) rand_req(1);
            if ($urandom_range(49) == 0) arb_mode = ~arb_mode;
            n_hreset = ($urandom_range(199) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
